ci_scratchpad_dma: RTL
======================

// Module: ci_scratchpad_dma
// PURPOSE
//  Custom-instruction scratchpad: the CPU reads and writes a parametrised on-chip RAM
//  through the CI handshake (start, valueA, valueB, iseId).
//  Adds an internal block engine that runs in the background while the CPU keeps
//  single-word access. The engine copies or fills memory, one word at a time.
//  Sits on the CPU custom-instruction bus next to the other CI blocks.
// PARAMETERS
//  CUSTOM_ID  8'h0D  iseId value this block answers to
//  ADDR_W     9      word address width; DEPTH = 2**ADDR_W
//  DATA_W     32     RAM word width (1..32); read data is zero-extended to 32 bits
// PORTS
//  clock   in   1   single system clock, rising edge
//  reset   in   1   asynchronous, active-high reset
//  start   in   1   CI request strobe, one cycle per instruction
//  iseId   in   8   CI identifier; the block acts only when start && iseId==CUSTOM_ID
//  valueA  in   32  [ADDR_W-1:0]=address, [ADDR_W]=write, [ADDR_W+3:ADDR_W+1]=func
//  valueB  in   32  write data / engine operand
//  done    out  1   instruction complete
//  result  out  32  return value, valid when done=1, otherwise 0
// BEHAVIOUR
//  Reset: done=0, result=0, engine IDLE, src/dst/len=0. RAM contents are not cleared.
//  func 0 with write=1: RAM[addr]<=valueB[DATA_W-1:0]. done is combinational in the
//    same cycle; result=0.
//  func 0 with write=0: synchronous read. done and result are registered and appear
//    one cycle after start. No other CI access may be issued in that cycle.
//  func 1, 2 and 3 load src, dst and len from valueB (ADDR_W, ADDR_W, ADDR_W+1 bits).
//    done is same-cycle; result=0.
//  func 4 = COPY, func 5 = FILL with pattern valueB. done is same-cycle (non-blocking).
//    result=0 if the job is accepted. result=1 if the engine is busy; the request is
//    then ignored and the registers are unchanged.
//  func 6 = STATUS. done is same-cycle; result = {busy, zeros, remaining[ADDR_W:0]}.
//  func 7 = ABORT. Engine goes to IDLE at the next edge, remaining=0, done same-cycle.
//    Words already written stay written.
//  Undefined or unmatched iseId: done=0. A start with a foreign iseId is ignored.
//  Engine FSM:
//    IDLE -> RD on COPY with len!=0.
//    IDLE -> WR on FILL with len!=0.
//    len==0 is a no-op and busy is never raised.
//    RD: read RAM[src] on port B -> WR.
//    WR: write the word to RAM[dst] on port B; src++ and dst++ modulo DEPTH;
//      remaining--. Next state is IDLE if remaining hits 0, else RD for COPY,
//      or WR again for FILL.
//    COPY moves one word per 2 cycles; FILL moves one word per cycle.
//  Collision rule: any cycle with a CPU write (port A) stalls the engine in its
//    current state, so the CPU write always lands and the engine never races it.
//  Overlapping src/dst: strict ascending word order. Forward overlap therefore
//    smears data, by definition.
//  CPU reads during a job return the current RAM contents and do not stall the engine.
//  Addresses wrap modulo DEPTH. len is taken from valueB[ADDR_W:0]; len=DEPTH is
//    the whole memory.
//  Reset mid-job: immediate return to IDLE, all registers cleared.
// STRUCTURE
//  Package ci_scratchpad_pkg holds:
//    func codes: FUNC_RW, FUNC_SRC, FUNC_DST, FUNC_LEN, FUNC_COPY, FUNC_FILL,
//      FUNC_STATUS, FUNC_ABORT
//    engine state enum: IDLE, RD, WR
//  One sub-module, dual_port_ram_sync (ADDR_W, DATA_W):
//    two synchronous ports, 1-cycle read, write-first per port.
//  CI decode and the engine FSM live in the top module.
// TESTING
//  1 Writes 0xFE,0x17,0x18,0x19 to addr 0..3 (valueA=512|a) -> done same cycle each;
//    reads of addr 2,1,3,0 -> done+1 cycle, result 0x18,0x17,0x19,0xFE.
//  2 src=0, dst=100, len=4, COPY -> result 0; STATUS shows busy=1.
//    After 8 cycles busy=0 and remaining=0; RAM[100..103]=0xFE,0x17,0x18,0x19.
//  3 FILL 0xA5 with dst=DEPTH-2, len=4 -> words DEPTH-2, DEPTH-1, 0, 1 all equal 0xA5
//    (wrap-around); completes in 4 cycles.
//  4 COPY len=8 with a CPU write every cycle during the job -> engine stalls.
//    All CPU writes land; the copy completes correctly after the writes stop.
//  5 A second COPY while busy -> result 1 and no effect. ABORT mid-job -> busy=0 and
//    the partial copy is left in place. COPY with len=0 -> busy never 1.
//  6 Assert reset mid-COPY -> done=0, result=0, STATUS busy=0, remaining=0.
//    Previously written RAM words are still readable.

Source files
------------

// File: rtl/ci_scratchpad_pkg.sv
// Shared definitions for the CI scratchpad: function codes, engine states and
// the debug view of the block engine.
package ci_scratchpad_pkg;

  localparam logic [2:0] FUNC_RW     = 3'd0;
  localparam logic [2:0] FUNC_SRC    = 3'd1;
  localparam logic [2:0] FUNC_DST    = 3'd2;
  localparam logic [2:0] FUNC_LEN    = 3'd3;
  localparam logic [2:0] FUNC_COPY   = 3'd4;
  localparam logic [2:0] FUNC_FILL   = 3'd5;
  localparam logic [2:0] FUNC_STATUS = 3'd6;
  localparam logic [2:0] FUNC_ABORT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } engineState_t;

  // Snapshot of the engine for checkers bound onto the top module.
  typedef struct packed {
    engineState_t state;
    logic         busy;
    logic         stall;
    logic         isCopy;
  } engineDbg_t;

endpackage

// File: rtl/dual_port_ram_sync.sv
// Two independent synchronous ports over one array; each port reads in one
// cycle and returns its own write data on a write (write-first).
module dual_port_ram_sync #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              enA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] wdataA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              enB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataB,
  output logic [DATA_W-1:0] rdataB
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both ports share one process so the array has a single driver; the
  // engine never writes in a cycle where port A writes.
  always_ff @(posedge clock) begin
    if (enA) begin
      if (weA) mem[addrA] <= wdataA;
      rdataA <= weA ? wdataA : mem[addrA];
    end
    if (enB) begin
      if (weB) mem[addrB] <= wdataB;
      rdataB <= weB ? wdataB : mem[addrB];
    end
  end

endmodule

// File: rtl/ci_scratchpad_dma.sv
// Custom-instruction scratchpad RAM with a background copy/fill engine.
// Port A serves the CPU, port B belongs to the engine.
module ci_scratchpad_dma
  import ci_scratchpad_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID = 8'h0D,
  parameter int         ADDR_W    = 9,
  parameter int         DATA_W    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  // CI handshake: a request is one start cycle with our iseId. done is raised
  // in that same cycle, except for RAM reads where done and result follow one
  // cycle later; result is zero whenever done is low.
  logic              hit;
  logic [2:0]        func;
  logic              wrBit;
  logic [ADDR_W-1:0] cpuAddr;
  logic              cpuWrite;
  logic              cpuRead;
  logic              abortReq;

  assign hit      = start && (iseId == CUSTOM_ID);
  assign func     = valueA[ADDR_W+3:ADDR_W+1];
  assign wrBit    = valueA[ADDR_W];
  assign cpuAddr  = valueA[ADDR_W-1:0];
  assign cpuWrite = hit && (func == FUNC_RW) && wrBit;
  assign cpuRead  = hit && (func == FUNC_RW) && !wrBit;
  assign abortReq = hit && (func == FUNC_ABORT);

  engineState_t      state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   remaining;
  logic              isCopy;
  logic [DATA_W-1:0] pattern;
  logic              readPending;

  logic              busy;
  logic              stall;
  logic              engStep;
  logic [DATA_W-1:0] rdataA;
  logic [DATA_W-1:0] rdataB;
  logic [DATA_W-1:0] wdataB;

  assign busy    = (state != IDLE);
  assign stall   = cpuWrite;
  assign engStep = busy && !stall && !abortReq;
  assign wdataB  = isCopy ? rdataB : pattern;

  engineDbg_t engineDbg;
  assign engineDbg = '{state: state, busy: busy, stall: stall, isCopy: isCopy};

  dual_port_ram_sync #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) ram (
    .clock (clock),
    .enA   (cpuWrite || cpuRead),
    .weA   (cpuWrite),
    .addrA (cpuAddr),
    .wdataA(valueB[DATA_W-1:0]),
    .rdataA(rdataA),
    .enB   (engStep),
    .weB   (state == WR),
    .addrB ((state == WR) ? dst : src),
    .wdataB(wdataB),
    .rdataB(rdataB)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      remaining   <= '0;
      isCopy      <= 1'b0;
      pattern     <= '0;
      readPending <= 1'b0;
    end else begin
      readPending <= cpuRead;
      if (hit) begin
        case (func)
          FUNC_SRC: src <= valueB[ADDR_W-1:0];
          FUNC_DST: dst <= valueB[ADDR_W-1:0];
          FUNC_LEN: len <= valueB[ADDR_W:0];
          default:  ;
        endcase
      end
      if (abortReq) begin
        state     <= IDLE;
        remaining <= '0;
      end else if (!busy) begin
        // A zero-length job never leaves IDLE.
        if (hit && (func == FUNC_COPY || func == FUNC_FILL) && len != '0) begin
          state     <= (func == FUNC_COPY) ? RD : WR;
          remaining <= len;
          isCopy    <= (func == FUNC_COPY);
          if (func == FUNC_FILL) pattern <= valueB[DATA_W-1:0];
        end
      end else if (engStep) begin
        case (state)
          RD: state <= WR;
          WR: begin
            src       <= src + ADDR_W'(1);
            dst       <= dst + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) state <= IDLE;
            else                             state <= isCopy ? RD : WR;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    done   = 1'b0;
    result = '0;
    if (readPending) begin
      done   = 1'b1;
      result = 32'(rdataA);
    end else if (hit) begin
      case (func)
        FUNC_RW:     done = wrBit;
        FUNC_COPY,
        FUNC_FILL: begin
          done   = 1'b1;
          result = 32'(busy);
        end
        FUNC_STATUS: begin
          done   = 1'b1;
          result = {busy, {(30-ADDR_W){1'b0}}, remaining};
        end
        default:     done = 1'b1;
      endcase
    end
  end

  // Upper operand bits carry no meaning for this block.
  logic unusedBits;
  assign unusedBits = &{1'b0, valueA[31:ADDR_W+4], valueB, engineDbg};

endmodule
